// File: rtl/key_debounce_array.sv
// key_debounce_array: N-channel key debouncer.
// Each raw pin is synchronised, normalised so that 1 means pressed, and then
// filtered on a shared prescaled sample tick. A new level is accepted only
// after SAMPLE consecutive disagreeing ticks. Each channel also produces
// one-cycle press/release pulses and a long-press hold flag.
module key_debounce_array #(
    parameter int N          = 4,
    parameter int SAMPLE     = 30,
    parameter int TICK_DIV   = 1,
    parameter int HOLD_TICKS = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_i,
    output logic [N-1:0] key_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o,
    output logic [N-1:0] hold_o
);

    // Counter widths sized to hold their terminal values without wrapping.
    localparam int CW = (SAMPLE > 1)     ? $clog2(SAMPLE)     : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;

    // Idle (released) pin level; also the synchroniser reset value.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_s;

    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  samp_s;

    logic [N-1:0]  key_q, key_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];
    logic [HW-1:0] hcnt_q [N];
    logic [HW-1:0] hcnt_d [N];

    assign tick_s = (pre_q == PW'(TICK_DIV - 1));
    assign samp_s = sync2_q ^ {N{IDLE_LVL}};

    // Shared prescaler: counts 0..TICK_DIV-1 and wraps on the tick cycle.
    always_comb begin
        pre_d = pre_q;
        if (tick_s) begin
            pre_d = {PW{1'b0}};
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Per-channel bounce filter and registered press/release pulse generation.
    always_comb begin
        key_d = key_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_s) begin
                if (samp_s[i] == key_q[i]) begin
                    cnt_d[i] = {CW{1'b0}};
                end else if (cnt_q[i] == CW'(SAMPLE - 1)) begin
                    key_d[i] = samp_s[i];
                    cnt_d[i] = {CW{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        // Pulses are registered alongside key_q, so they show during the
        // first cycle the new level is visible.
        press_d   = key_d & ~key_q;
        release_d = ~key_d & key_q;
    end

    // Per-channel hold timer; clears together with the falling debounced level.
    always_comb begin
        hold_d = hold_q;
        for (int i = 0; i < N; i++) begin
            hcnt_d[i] = hcnt_q[i];
            if (!key_q[i] || !key_d[i]) begin
                hcnt_d[i] = {HW{1'b0}};
                hold_d[i] = 1'b0;
            end else if (tick_s && !hold_q[i]) begin
                if (hcnt_q[i] == HW'(HOLD_TICKS - 1)) begin
                    hold_d[i] = 1'b1;
                end else begin
                    hcnt_d[i] = hcnt_q[i] + HW'(1);
                end
            end else begin
                hcnt_d[i] = hcnt_q[i];
                hold_d[i] = hold_q[i];
            end
        end
    end

    // State registers with asynchronous reset to the idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= {PW{1'b0}};
            sync1_q   <= {N{IDLE_LVL}};
            sync2_q   <= {N{IDLE_LVL}};
            key_q     <= {N{1'b0}};
            press_q   <= {N{1'b0}};
            release_q <= {N{1'b0}};
            hold_q    <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= {CW{1'b0}};
                hcnt_q[i] <= {HW{1'b0}};
            end
        end else begin
            pre_q     <= pre_d;
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign key_o     = key_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: three instances cover the base
// configuration, active-low pins, and a prescaled sample tick.
module tb_key_debounce_array;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_a, ko_a, pr_a, rl_a, ho_a;
    logic [3:0] key_b, ko_b, pr_b, rl_b, ho_b;
    logic [3:0] key_c, ko_c, pr_c, rl_c, ho_c;

    int n_vec;
    int n_err;

    key_debounce_array #(.N(4), .SAMPLE(4), .TICK_DIV(1), .HOLD_TICKS(10), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .key_i(key_a),
        .key_o(ko_a), .press_o(pr_a), .release_o(rl_a), .hold_o(ho_a)
    );

    key_debounce_array #(.N(4), .SAMPLE(4), .TICK_DIV(1), .HOLD_TICKS(10), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_i(key_b),
        .key_o(ko_b), .press_o(pr_b), .release_o(rl_b), .hold_o(ho_b)
    );

    key_debounce_array #(.N(4), .SAMPLE(4), .TICK_DIV(5), .HOLD_TICKS(10), .ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .key_i(key_c),
        .key_o(ko_c), .press_o(pr_c), .release_o(rl_c), .hold_o(ho_c)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0] acc;
        logic       kacc;
        logic       ok;
        logic       prev_h;
        int         pc;
        int         lat;
        int         found;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        key_a = 4'h0;
        key_b = 4'hF;
        key_c = 4'h0;

        // ---- reset with random pins ----
        #2;
        rst_n = 1'b0;
        key_a = 4'($urandom);
        step(3);
        check_val("rst_a_outputs", {ko_a, pr_a, rl_a, ho_a}, 32'h0);
        check_val("rst_b_outputs", {ko_b, pr_b, rl_b, ho_b}, 32'h0);
        check_val("rst_c_outputs", {ko_c, pr_c, rl_c, ho_c}, 32'h0);
        key_a = 4'h0;
        rst_n = 1'b1;
        acc = 4'h0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            acc = acc | pr_a | rl_a | pr_b | rl_b | ko_a | ko_b;
        end
        check_val("post_rst_quiet", 32'(acc), 32'h0);

        // ---- clean press/release on channel 0, latency SAMPLE+2 ----
        key_a[0] = 1'b1;
        step(5);
        check_val("press_early", 32'(ko_a), 32'h0);
        step(1);
        check_val("press_key", 32'(ko_a), 32'h1);
        check_val("press_pulse", 32'(pr_a), 32'h1);
        step(1);
        check_val("press_pulse_end", 32'({pr_a, rl_a}), 32'h0);
        key_a[0] = 1'b0;
        step(5);
        check_val("release_early", 32'(ko_a), 32'h1);
        step(1);
        check_val("release_key", 32'(ko_a), 32'h0);
        check_val("release_pulse", 32'(rl_a), 32'h1);
        check_val("release_no_hold", 32'(ho_a), 32'h0);
        step(1);
        check_val("release_pulse_end", 32'(rl_a), 32'h0);

        // ---- bounce on channel 1: 3 high / 1 low never qualifies ----
        acc  = 4'h0;
        kacc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            key_a[1] = ((i % 4) != 3) ? 1'b1 : 1'b0;
            step(1);
            acc  = acc | pr_a | rl_a;
            kacc = kacc | ko_a[1];
        end
        check_val("bounce_no_pulse", 32'(acc), 32'h0);
        check_val("bounce_key_low", 32'(kacc), 32'h0);
        key_a[1] = 1'b1;
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            pc += int'(pr_a[1]);
        end
        check_val("bounce_one_press", 32'(pc), 32'd1);
        check_val("bounce_key_high", 32'(ko_a[1]), 32'h1);

        // ---- hold on channel 2 ----
        key_a[2] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (ko_a[2]) found = 1;
        end
        check_val("hold_key_rise", 32'(found), 32'd1);
        lat = 0;
        for (int e = 1; e <= 30 && lat == 0; e++) begin
            step(1);
            if (ho_a[2]) lat = e;
        end
        check_val("hold_latency", 32'(lat), 32'd10);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            ok = ok & ho_a[2];
        end
        check_val("hold_stays", 32'(ok), 32'h1);
        key_a[2] = 1'b0;
        prev_h = ho_a[2];
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (!ko_a[2]) begin
                found = 1;
                check_val("hold_prev_high", 32'(prev_h), 32'h1);
                check_val("hold_fall_same", 32'(ho_a[2]), 32'h0);
                check_val("hold_release", 32'(rl_a[2]), 32'h1);
            end else begin
                prev_h = ho_a[2];
            end
        end
        check_val("hold_key_fall", 32'(found), 32'd1);

        // ---- active-low, all channels together ----
        check_val("al_idle_key", 32'(ko_b), 32'h0);
        key_b = 4'h0;
        step(5);
        check_val("al_early", 32'(ko_b), 32'h0);
        step(1);
        check_val("al_key_all", 32'(ko_b), 32'hF);
        check_val("al_press_all", 32'(pr_b), 32'hF);

        // ---- prescaled tick: latency window and pulse width ----
        key_c[0] = 1'b1;
        lat = 0;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            step(1);
            if (ko_c[0]) lat = e;
        end
        check_val("pre_lat_range", 32'((lat >= 18) && (lat <= 22)), 32'h1);
        check_val("pre_press", 32'(pr_c), 32'h1);
        step(1);
        check_val("pre_press_width", 32'(pr_c), 32'h0);
        key_c[0] = 1'b0;
        step(40);
        check_val("pre_released", 32'(ko_c), 32'h0);

        // ---- mid-count reset restarts the full latency ----
        key_c[0] = 1'b1;
        step(10);
        check_val("mid_not_yet", 32'(ko_c), 32'h0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_outputs", {ko_c, pr_c, rl_c, ho_c}, 32'h0);
        step(2);
        rst_n = 1'b1;
        lat = 0;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            step(1);
            if (ko_c[0]) lat = e;
        end
        check_val("mid_rst_latency", 32'(lat), 32'd20);
        check_val("mid_rst_press", 32'(pr_c), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
